// File: rtl/posit_encoder_rnd.sv
// Pipelined posit rounder/encoder: decoded scale/fraction/g-r-s/flags -> N-bit posit word.
// Round-to-nearest-even on the packed bit string, saturating to maxpos/minpos; 3 stages, valid/ready.
module posit_encoder_rnd #(
  parameter int POSIT_WIDTH = 16,
  parameter int POSIT_ES    = 1,
  parameter int SCALE_WIDTH = 8,
  parameter int FRAC_WIDTH  = POSIT_WIDTH - POSIT_ES - 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [SCALE_WIDTH-1:0] in_scale,
  input  logic [FRAC_WIDTH-1:0]         in_fraction,
  input  logic                          in_guard,
  input  logic                          in_round,
  input  logic                          in_sticky,
  input  logic                          in_sign,
  input  logic                          in_zero,
  input  logic                          in_NaR,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [POSIT_WIDTH-1:0]        out_posit
);
  localparam int N   = POSIT_WIDTH;
  localparam int ES  = POSIT_ES;
  localparam int EW  = (ES > 0) ? ES : 1;
  localparam int TW  = ES + FRAC_WIDTH + 2;   // e, fraction, guard, round
  localparam int FW  = N + TW + 1;
  localparam int RLW = $clog2(N + 1);
  localparam int XW  = SCALE_WIDTH + 2;

  localparam logic signed [XW-1:0] SAT_MAX = XW'((N - 2) << ES);
  localparam logic signed [XW-1:0] SAT_MIN = -SAT_MAX;
  localparam logic signed [XW-1:0] N_X     = XW'(N);

  // ---------------- handshake ----------------
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic s1_ready, s2_ready, s3_ready;

  assign s3_ready  = !s3_valid_q || out_ready;
  assign s2_ready  = !s2_valid_q || s3_ready;
  assign s1_ready  = !s1_valid_q || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s3_valid_q;

  // ---------------- stage 1: regime decode ----------------
  logic signed [XW-1:0]          scale_x, k_x, rl_x;
  logic signed [SCALE_WIDTH-1:0] k_d;
  logic [EW-1:0]                 e_d;
  logic [RLW-1:0]                rl_d;
  logic                          sat_hi_d, sat_lo_d;

  generate
    if (ES > 0) begin : g_e_field
      assign e_d = in_scale[EW-1:0];
    end else begin : g_e_none
      assign e_d = '0;
    end
  endgenerate

  always_comb begin
    scale_x  = {{2{in_scale[SCALE_WIDTH-1]}}, in_scale};
    k_d      = in_scale >>> ES;
    k_x      = {{2{k_d[SCALE_WIDTH-1]}}, k_d};
    // Regime length including terminator; anything longer than N is truncated anyway.
    rl_x     = k_d[SCALE_WIDTH-1] ? (XW'(1) - k_x) : (k_x + XW'(2));
    rl_d     = (rl_x > N_X) ? RLW'(N) : rl_x[RLW-1:0];
    sat_hi_d = scale_x > SAT_MAX;
    sat_lo_d = scale_x < SAT_MIN;
  end

  logic                  s1_kneg_q, s1_sat_hi_q, s1_sat_lo_q;
  logic [RLW-1:0]        s1_rl_q;
  logic [EW-1:0]         s1_e_q;
  logic [FRAC_WIDTH-1:0] s1_frac_q;
  logic                  s1_g_q, s1_r_q, s1_s_q, s1_sign_q, s1_zero_q, s1_nar_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_kneg_q   <= 1'b0;
      s1_sat_hi_q <= 1'b0;
      s1_sat_lo_q <= 1'b0;
      s1_rl_q     <= '0;
      s1_e_q      <= '0;
      s1_frac_q   <= '0;
      s1_g_q      <= 1'b0;
      s1_r_q      <= 1'b0;
      s1_s_q      <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_nar_q    <= 1'b0;
    end else begin
      if (s1_ready) s1_valid_q <= in_valid;
      if (s1_ready && in_valid) begin
        s1_kneg_q   <= k_d[SCALE_WIDTH-1];
        s1_sat_hi_q <= sat_hi_d;
        s1_sat_lo_q <= sat_lo_d;
        s1_rl_q     <= rl_d;
        s1_e_q      <= e_d;
        s1_frac_q   <= in_fraction;
        s1_g_q      <= in_guard;
        s1_r_q      <= in_round;
        s1_s_q      <= in_sticky;
        s1_sign_q   <= in_sign;
        s1_zero_q   <= in_zero;
        s1_nar_q    <= in_NaR;
      end
    end
  end

  // ---------------- stage 2: pack body and extract L/G/S ----------------
  logic [TW-1:0] tail;
  logic [FW-1:0] body_sh, regime_bits, field;
  logic [N-2:0]  kept_d;
  logic          g_d, s_d;

  generate
    if (ES > 0) begin : g_tail_e
      assign tail = {s1_e_q, s1_frac_q, s1_g_q, s1_r_q};
    end else begin : g_tail_noe
      assign tail = {s1_frac_q, s1_g_q, s1_r_q};
    end
  endgenerate

  always_comb begin
    body_sh = {tail, {(N + 1){1'b0}}} >> s1_rl_q;
    // k>=0: rl-1 leading ones then a zero; k<0: rl-1 zeros then a single one.
    if (s1_kneg_q) regime_bits = {1'b1, {(FW - 1){1'b0}}} >> (s1_rl_q - RLW'(1));
    else           regime_bits = ~({FW{1'b1}} >> (s1_rl_q - RLW'(1)));
    field  = body_sh | regime_bits;
    kept_d = field[FW-1 -: N-1];
    g_d    = field[FW-N];
    s_d    = (|field[FW-N-1:0]) | s1_r_q | s1_s_q;
  end

  logic [N-2:0] s2_kept_q;
  logic         s2_g_q, s2_s_q, s2_sat_hi_q, s2_sat_lo_q, s2_sign_q, s2_zero_q, s2_nar_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_kept_q   <= '0;
      s2_g_q      <= 1'b0;
      s2_s_q      <= 1'b0;
      s2_sat_hi_q <= 1'b0;
      s2_sat_lo_q <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_nar_q    <= 1'b0;
    end else begin
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (s2_ready && s1_valid_q) begin
        s2_kept_q   <= kept_d;
        s2_g_q      <= g_d;
        s2_s_q      <= s_d;
        s2_sat_hi_q <= s1_sat_hi_q;
        s2_sat_lo_q <= s1_sat_lo_q;
        s2_sign_q   <= s1_sign_q;
        s2_zero_q   <= s1_zero_q;
        s2_nar_q    <= s1_nar_q;
      end
    end
  end

  // ---------------- stage 3: round, saturate, negate ----------------
  logic         inc;
  logic [N-1:0] mag_sum, mag, posit_d;

  always_comb begin
    inc     = s2_g_q & (s2_kept_q[0] | s2_s_q);
    mag_sum = {1'b0, s2_kept_q} + {{(N - 1){1'b0}}, inc};
    // Rounding never produces zero or NaR: clamp to minpos/maxpos instead.
    if (s2_sat_hi_q || mag_sum[N-1])      mag = {1'b0, {(N - 1){1'b1}}};
    else if (s2_sat_lo_q || mag_sum == '0) mag = {{(N - 1){1'b0}}, 1'b1};
    else                                   mag = mag_sum;
    if (s2_nar_q)       posit_d = {1'b1, {(N - 1){1'b0}}};
    else if (s2_zero_q) posit_d = '0;
    else if (s2_sign_q) posit_d = -mag;
    else                posit_d = mag;
  end

  logic [N-1:0] s3_posit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_posit_q <= '0;
    end else begin
      if (s3_ready) s3_valid_q <= s2_valid_q;
      if (s3_ready && s2_valid_q) s3_posit_q <= posit_d;
    end
  end

  assign out_posit = s3_posit_q;

endmodule

// File: tb/tb_posit_encoder_rnd.sv
// Bench for posit_encoder_rnd: directed vector table, latency/backpressure/reset sequences,
// and 10k random ops scored against a bit-string reference model.
`timescale 1ns/1ps
module tb_posit_encoder_rnd;
  localparam int N   = 16;
  localparam int ES  = 1;
  localparam int SW  = 8;
  localparam int FRW = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [SW-1:0] in_scale = '0;
  logic [FRW-1:0]       in_fraction = '0;
  logic                 in_guard = 1'b0, in_round = 1'b0, in_sticky = 1'b0;
  logic                 in_sign = 1'b0, in_zero = 1'b0, in_NaR = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [N-1:0]         out_posit;

  always #5 clk = ~clk;

  posit_encoder_rnd #(.POSIT_WIDTH(N), .POSIT_ES(ES), .SCALE_WIDTH(SW), .FRAC_WIDTH(FRW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_scale(in_scale), .in_fraction(in_fraction),
    .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
    .in_sign(in_sign), .in_zero(in_zero), .in_NaR(in_NaR),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
  );

  // flags = {guard, round, sticky, sign, zero, NaR}
  typedef struct {
    int          scale;
    logic [11:0] frac;
    logic [5:0]  flags;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl[24];
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b1;
  bit          verbose = 1'b1;
  bit          rand_ready = 1'b0;

  // Reference: write out regime/e/fraction/g/r as a bit string, keep N-1 bits, round RNE.
  function automatic logic [15:0] ref_posit(int scale, logic [11:0] frac, logic [5:0] fl);
    bit q[$];
    int k, e, kept, gb, sb, maxsc;
    logic [15:0] res;
    if (fl[0]) return 16'h8000;
    if (fl[1]) return 16'h0000;
    maxsc = (N - 2) << ES;
    if (scale > maxsc) kept = (1 << (N - 1)) - 1;
    else if (scale < -maxsc) kept = 1;
    else begin
      k = scale >>> ES;
      e = scale - (k <<< ES);
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int b = ES - 1; b >= 0; b--) q.push_back(bit'((e >> b) & 1));
      for (int b = FRW - 1; b >= 0; b--) q.push_back(frac[b]);
      q.push_back(fl[5]);
      q.push_back(fl[4]);
      kept = 0;
      for (int i = 0; i < N - 1; i++) kept = kept * 2 + int'(q[i]);
      gb = int'(q[N-1]);
      sb = int'(fl[3]);
      for (int i = N; i < q.size(); i++) sb = sb | int'(q[i]);
      if (gb != 0 && ((kept & 1) != 0 || sb != 0)) kept++;
      if (kept >= (1 << (N - 1))) kept = (1 << (N - 1)) - 1;
      if (kept == 0) kept = 1;
    end
    res = 16'(kept);
    if (fl[2]) res = -res;
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int scale, input logic [11:0] frac, input logic [5:0] fl,
                       input logic [15:0] exp);
    int  n;
    bit  ok;
    in_scale    = SW'(scale);
    in_fraction = frac;
    {in_guard, in_round, in_sticky, in_sign, in_zero, in_NaR} = fl;
    in_valid    = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (ok) exp_q.push_back(exp);
    else begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout got=in_ready_low expected=accept scale=%0d", scale);
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_scale    = SW'($urandom);
    in_fraction = FRW'($urandom);
    {in_guard, in_round, in_sticky, in_sign, in_zero, in_NaR} = 6'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output got=%h expected=none", out_posit);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_posit !== mon_exp) begin
          miscompares++;
          $display("FAIL out_posit got=%h expected=%h", out_posit, mon_exp);
        end else if (verbose) begin
          $display("out_posit %h ok", out_posit);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    tbl[0]  = '{0,   12'h000, 6'b000000, 16'h4000};
    tbl[1]  = '{1,   12'h000, 6'b000000, 16'h5000};
    tbl[2]  = '{-1,  12'h000, 6'b000000, 16'h3000};
    tbl[3]  = '{0,   12'h000, 6'b000100, 16'hC000};
    tbl[4]  = '{5,   12'hABC, 6'b111101, 16'h8000};
    tbl[5]  = '{0,   12'h000, 6'b000110, 16'h0000};
    tbl[6]  = '{40,  12'hFFF, 6'b100010, 16'h0000};
    tbl[7]  = '{0,   12'h000, 6'b100000, 16'h4000};
    tbl[8]  = '{0,   12'h001, 6'b100000, 16'h4002};
    tbl[9]  = '{0,   12'h000, 6'b101000, 16'h4001};
    tbl[10] = '{0,   12'h000, 6'b110000, 16'h4001};
    tbl[11] = '{0,   12'h000, 6'b010000, 16'h4000};
    tbl[12] = '{28,  12'h000, 6'b000000, 16'h7FFF};
    tbl[13] = '{40,  12'h000, 6'b000000, 16'h7FFF};
    tbl[14] = '{-40, 12'h000, 6'b000000, 16'h0001};
    tbl[15] = '{-40, 12'h000, 6'b000100, 16'hFFFF};
    tbl[16] = '{27,  12'hFFF, 6'b100000, 16'h7FFF};
    tbl[17] = '{-28, 12'h000, 6'b000000, 16'h0001};
    tbl[18] = '{2,   12'h800, 6'b000000, 16'h6400};
    tbl[19] = '{-3,  12'hABC, 6'b000000, 16'h1D5E};
    tbl[20] = '{-3,  12'hABC, 6'b000100, 16'hE2A2};
    tbl[21] = '{1,   12'hFFF, 6'b100000, 16'h6000};
    tbl[22] = '{29,  12'h000, 6'b000100, 16'h8001};
    tbl[23] = '{-29, 12'h000, 6'b000000, 16'h0001};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_posit", 32'(out_posit), 32'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // directed table, back-to-back
    for (int i = 0; i < 24; i++) drive(tbl[i].scale, tbl[i].frac, tbl[i].flags, tbl[i].exp);
    wait_drain("table_drain");

    // latency: capture edge counts as edge 1, output valid after edge 3
    drive(tbl[1].scale, tbl[1].frac, tbl[1].flags, tbl[1].exp);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge2_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge3_valid", 32'(out_valid), 32'd1);
    check("lat_edge3_posit", 32'(out_posit), 32'(tbl[1].exp));
    wait_drain("lat_drain");

    // backpressure: fill the pipe with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(tbl[i].scale, tbl[i].frac, tbl[i].flags, tbl[i].exp);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_posit", 32'(out_posit), 32'(tbl[0].exp));
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain("bp_drain");

    // async reset with three ops in flight
    for (int i = 12; i < 15; i++) drive(tbl[i].scale, tbl[i].frac, tbl[i].flags, tbl[i].exp);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_posit", 32'(out_posit), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end

    // random ops against the reference model, random consumer stalls
    verbose    = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      int              sc;
      logic signed [7:0] t8;
      logic [11:0]     fr;
      logic [5:0]      fl;
      if ($urandom_range(0, 7) == 0) begin
        t8 = 8'($urandom);
        sc = t8;
      end else begin
        sc = int'($urandom_range(0, 64)) - 32;
      end
      fr = 12'($urandom);
      fl = {3'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0)};
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
      drive(sc, fr, fl, ref_posit(sc, fr, fl));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
